// File: rtl/pe_rf_loader_pkg.sv
// Shared PE loader definitions.
// State encoding and register-file geometry.
package pe_rf_loader_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int RF_DEPTH   = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/pe_rf_loader_if.sv
// Upstream word stream into the loader.
// Producer drives valid/data, loader drives ready.
interface pe_rf_loader_if #(
  parameter int DATA_W = 16
) ();

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/pe_rf_loader.sv
// Burst loader from a word stream into the PE register file.
// Writes are registered; done coincides with the last write.
module pe_rf_loader
  import pe_rf_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  pe_rf_loader_if.slave     in_if,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              start_err
);

  localparam logic [ADDR_W:0] MAX_CNT =
    (ADDR_W+1)'(2 ** ADDR_W);

  ld_state_e         state;
  ld_state_e         state_n;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   count_c;
  logic              beat;
  logic              launch;

  assign count_c = (count > MAX_CNT) ? MAX_CNT : count;

  assign in_if.in_ready = (state == ST_LOAD);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // abort wins over a beat presented in the same cycle
  always_comb begin
    state_n = state;
    beat    = 1'b0;
    launch  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (count_c == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_LOAD;
            launch  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (in_if.in_valid) begin
          beat = 1'b1;
          if (remaining == (ADDR_W+1)'(1)) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (launch) begin
      addr      <= base_addr;
      remaining <= count_c;
    end else if (beat) begin
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      start_err <= 1'b0;
    end else begin
      rf_we     <= beat;
      start_err <= start && (state != ST_IDLE);
      if (beat) begin
        rf_waddr <= addr;
        rf_wdata <= in_if.in_data;
      end
    end
  end

endmodule

// File: doc/pe_rf_loader.md
PE_RF_LOADER -- requirements
Module: pe_rf_loader

Interface
REQ-001 Parameter DATA_W, default 16, width of each loaded data word and of rf_wdata.
REQ-002 Parameter ADDR_W, default 4, register-file address width; depth is 2**ADDR_W (16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high; the design has one clock.
REQ-005 start  input  1  one-cycle request to begin a load burst; sampled in IDLE only.
REQ-006 base_addr  input  ADDR_W  first register address of the burst; sampled with start.
REQ-007 count  input  ADDR_W+1  number of words in the burst (0..16); sampled with start.
REQ-008 abort  input  1  terminates an active burst.
REQ-009 in_valid  input  1  upstream word valid.
REQ-010 in_data  input  DATA_W  upstream word.
REQ-011 in_ready  output  1  loader accepts a word this cycle.
REQ-012 rf_we  output  1  register-file write enable, registered.
REQ-013 rf_waddr  output  ADDR_W  register-file write address, registered.
REQ-014 rf_wdata  output  DATA_W  register-file write data, registered.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 done  output  1  one-cycle pulse when a burst completes normally.
REQ-017 start_err  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-018 FSM states: IDLE, LOAD, DONE.
REQ-019 IDLE with start=1 and count>0: latch base_addr into addr and count into remaining, then go to LOAD.
REQ-020 IDLE with start=1 and count=0: go to DONE directly and perform no write.
REQ-021 in_ready = 1 only in LOAD; it is a function of state only, with no combinational path from in_valid.
REQ-022 A beat is accepted when in_valid and in_ready are both 1.
REQ-023 On each beat: next cycle rf_we=1, rf_waddr=addr, rf_wdata=in_data; addr increments modulo 2**ADDR_W (15 wraps to 0); remaining decrements.
REQ-024 rf_we = 0 in every cycle that follows a cycle with no accepted beat; rf_waddr and rf_wdata hold their values when rf_we=0.
REQ-025 Accepting the beat with remaining=1 moves the FSM to DONE; the final rf_we and done both assert in that DONE cycle.
REQ-026 DONE always returns to IDLE after one cycle; done=1 only while in DONE.
REQ-027 in_valid low during LOAD inserts stalls with no writes; there is no timeout.
REQ-028 abort=1 in LOAD forces IDLE next cycle, accepts no beat that cycle, and produces no done; a write already registered in the previous cycle still completes.
REQ-029 abort is ignored in IDLE and DONE.
REQ-030 start while busy (LOAD or DONE) is ignored and pulses start_err next cycle; the active burst is unaffected.
REQ-031 If abort and start are both high in LOAD: abort takes effect and start_err pulses.
REQ-032 count > 16 is clamped to 16.

Reset
REQ-033 rst=1 at a clock edge forces: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, busy 0, done 0, start_err 0, in_ready 0, addr 0, remaining 0.
REQ-034 Reset during LOAD discards the burst; no write or done follows reset release.

Structure
REQ-035 The FSM state encoding, the DATA_W/ADDR_W defaults and the RF depth constant live in the shared NPU definitions header.
REQ-036 The block is a single module with no sub-modules; its rf_* outputs connect directly to the PE register file write port.

Verification
REQ-037 Basic burst: base=2, count=3, words A1,B2,C3 back-to-back -> rf writes (2,A1),(3,B2),(4,C3) on consecutive cycles; done occurs with the (4,C3) write.
REQ-038 Wrap-around: base=14, count=4 -> writes to addresses 14,15,0,1 in order; done=1 once.
REQ-039 Stalls: base=0, count=2 with in_valid low for 3 cycles between beats -> exactly 2 writes; in_ready stays 1 throughout LOAD.
REQ-040 Abort: base=5, count=4, abort after 2 beats -> writes only to 5 and 6, no done, busy=0 on the next cycle.
REQ-041 Zero count and busy start: start with count=0 -> done one cycle later with no rf_we; start during LOAD -> start_err pulse and the original burst still completes intact.
REQ-042 Reset mid-burst: rst asserted after 1 of 3 beats -> all outputs are 0 next cycle; no further writes until a new start.
